stopwatch_core: RTL and testbench

STOPWATCH_CORE -- requirements
Module: stopwatch_core

---
 rtl/stopwatch_core.sv | 162 ++++++++++++++++
 tb/tb_stopwatch_core.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_core.sv
// rtl/stopwatch_core.sv - BCD stopwatch core (M:SS.CC) with optional lap freeze.
// Optional lap feature enabled by defining STOPWATCH_LAP_EN.
module stopwatch_core #(
  parameter int MIN_MAX = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk100,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] disp_m,
  output logic [3:0] disp_s10,
  output logic [3:0] disp_s1,
  output logic [3:0] disp_cs10,
  output logic [3:0] disp_cs1,
  output logic       running,
  output logic       wrap,
  output logic       lap_active
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  localparam logic [3:0] M_LIM = 4'(MIN_MAX);

  state_t     state_q, state_d;
  logic       sync1_q, sync2_q, hist_q;
  logic       ss_hist_q, clr_hist_q, lap_hist_q, lap_hist_d;
  logic [3:0] m_q, s10_q, s1_q, cs10_q, cs1_q;
  logic [3:0] m_d, s10_d, s1_d, cs10_d, cs1_d;
  logic [19:0] disp_q, disp_d;
  logic       wrap_q, wrap_d;
  logic       lap_active_q, lap_active_d;
  logic       tick, ss_ev, clr_ev, disp_load;

  assign tick   = sync2_q & ~hist_q;
  assign ss_ev  = start_stop & ~ss_hist_q;
  assign clr_ev = clear & ~clr_hist_q;

  always_comb begin
    state_d = state_q;
    if (clr_ev) begin
      state_d = IDLE;
    end else if (ss_ev) begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = HOLD;
        HOLD:    state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Ripple BCD carry; only the pre-edge RUN state lets a tick count.
  always_comb begin
    m_d    = m_q;
    s10_d  = s10_q;
    s1_d   = s1_q;
    cs10_d = cs10_q;
    cs1_d  = cs1_q;
    wrap_d = 1'b0;
    if (clr_ev) begin
      m_d = 4'd0; s10_d = 4'd0; s1_d = 4'd0; cs10_d = 4'd0; cs1_d = 4'd0;
    end else if (tick && state_q == RUN) begin
      if (cs1_q < 4'd9) cs1_d = cs1_q + 4'd1;
      else begin
        cs1_d = 4'd0;
        if (cs10_q < 4'd9) cs10_d = cs10_q + 4'd1;
        else begin
          cs10_d = 4'd0;
          if (s1_q < 4'd9) s1_d = s1_q + 4'd1;
          else begin
            s1_d = 4'd0;
            if (s10_q < 4'd5) s10_d = s10_q + 4'd1;
            else begin
              s10_d = 4'd0;
              if (m_q < M_LIM) m_d = m_q + 4'd1;
              else begin
                m_d    = 4'd0;
                wrap_d = 1'b1;
              end
            end
          end
        end
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic lap_ev;
  assign lap_ev = lap & ~lap_hist_q;

  always_comb begin
    lap_hist_d   = lap;
    lap_active_d = lap_active_q;
    if (clr_ev)
      lap_active_d = 1'b0;
    else if (lap_ev && lap_active_q)
      lap_active_d = 1'b0;
    else if (lap_ev && state_q == RUN)
      lap_active_d = 1'b1;
    // Hold only while frozen before and after; capture and release both reload.
    disp_load = !(lap_active_q && lap_active_d);
  end
`else
  logic lap_unused;
  assign lap_unused = lap;

  always_comb begin
    lap_hist_d   = 1'b0;
    lap_active_d = 1'b0;
    disp_load    = 1'b1;
  end
`endif

  always_comb begin
    disp_d = disp_q;
    if (disp_load) disp_d = {m_q, s10_q, s1_q, cs10_q, cs1_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      hist_q       <= 1'b0;
      ss_hist_q    <= 1'b0;
      clr_hist_q   <= 1'b0;
      lap_hist_q   <= 1'b0;
      m_q          <= 4'd0;
      s10_q        <= 4'd0;
      s1_q         <= 4'd0;
      cs10_q       <= 4'd0;
      cs1_q        <= 4'd0;
      disp_q       <= 20'd0;
      wrap_q       <= 1'b0;
      lap_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= clk100;
      sync2_q      <= sync1_q;
      hist_q       <= sync2_q;
      ss_hist_q    <= start_stop;
      clr_hist_q   <= clear;
      lap_hist_q   <= lap_hist_d;
      m_q          <= m_d;
      s10_q        <= s10_d;
      s1_q         <= s1_d;
      cs10_q       <= cs10_d;
      cs1_q        <= cs1_d;
      disp_q       <= disp_d;
      wrap_q       <= wrap_d;
      lap_active_q <= lap_active_d;
    end
  end

  assign {disp_m, disp_s10, disp_s1, disp_cs10, disp_cs1} = disp_q;
  assign running    = (state_q == RUN);
  assign wrap       = wrap_q;
  assign lap_active = lap_active_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// tb/tb_stopwatch_core.sv - directed table-driven bench for stopwatch_core (MIN_MAX=1).
`timescale 1ns/1ps
module tb_stopwatch_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk100 = 1'b0;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic       lap = 1'b0;
  logic [3:0] disp_m, disp_s10, disp_s1, disp_cs10, disp_cs1;
  logic       running, wrap, lap_active;

  int tests = 0;
  int fails = 0;

  stopwatch_core #(.MIN_MAX(1)) dut (
    .clk(clk), .rst_n(rst_n), .clk100(clk100),
    .start_stop(start_stop), .clear(clear), .lap(lap),
    .disp_m(disp_m), .disp_s10(disp_s10), .disp_s1(disp_s1),
    .disp_cs10(disp_cs10), .disp_cs1(disp_cs1),
    .running(running), .wrap(wrap), .lap_active(lap_active)
  );

  always #10 clk = ~clk;

  typedef struct {
    string       name;
    bit          clr;
    bit          ss;
    int          ticks;
    logic [19:0] exp_disp;
    bit          exp_run;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [19:0] disp_now();
    return {disp_m, disp_s10, disp_s1, disp_cs10, disp_cs1};
  endfunction

  task automatic cmp(input string name, input logic [19:0] act, input logic [19:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check(input string name, input logic [19:0] exp_disp, input bit exp_run,
                       input bit exp_lap);
    cmp({name, ".disp"}, disp_now(), exp_disp);
    cmp({name, ".running"}, 20'(running), 20'(exp_run));
    cmp({name, ".lap_active"}, 20'(lap_active), 20'(exp_lap));
    cmp({name, ".wrap"}, 20'(wrap), 20'd0);
  endtask

  task automatic tick();
    @(negedge clk) clk100 = 1'b1;
    @(negedge clk);
    @(negedge clk) clk100 = 1'b0;
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  task automatic press(input int which);
    @(negedge clk);
    if (which == 0) start_stop = 1'b1;
    else if (which == 1) clear = 1'b1;
    else lap = 1'b1;
    @(negedge clk);
    start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
    settle();
  endtask

  initial begin
    #1900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int wrap_hi;
    vecs[0] = '{"start_150",   1'b0, 1'b1, 150,  20'h00150, 1'b1};
    vecs[1] = '{"hold",        1'b0, 1'b1, 0,    20'h00150, 1'b0};
    vecs[2] = '{"hold_ticks",  1'b0, 1'b0, 20,   20'h00150, 1'b0};
    vecs[3] = '{"resume_57",   1'b0, 1'b1, 57,   20'h00207, 1'b1};
    vecs[4] = '{"hold2",       1'b0, 1'b1, 0,    20'h00207, 1'b0};
    vecs[5] = '{"clear_hold",  1'b1, 1'b0, 0,    20'h00000, 1'b0};
    vecs[6] = '{"idle_ticks",  1'b0, 1'b0, 10,   20'h00000, 1'b0};
    vecs[7] = '{"carry_s10",   1'b0, 1'b1, 1009, 20'h01009, 1'b1};
    vecs[8] = '{"carry_min",   1'b0, 1'b0, 4991, 20'h10000, 1'b1};
    vecs[9] = '{"clear_run",   1'b1, 1'b0, 0,    20'h00000, 1'b0};

    #5;
    check("reset", 20'h00000, 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    settle();

    foreach (vecs[i]) begin
      if (vecs[i].clr) press(1);
      if (vecs[i].ss) press(0);
      ticks(vecs[i].ticks);
      settle();
      check(vecs[i].name, vecs[i].exp_disp, vecs[i].exp_run, 1'b0);
    end

    // Rollover from 1:59.99 with a single-cycle wrap pulse.
    press(0);
    ticks(11999);
    settle();
    check("pre_wrap", 20'h15999, 1'b1, 1'b0);
    wrap_hi = 0;
    @(negedge clk) clk100 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 1) clk100 = 1'b0;
      if (wrap) wrap_hi++;
    end
    cmp("wrap_pulse_cycles", 20'(wrap_hi), 20'd1);
    check("post_wrap", 20'h00000, 1'b1, 1'b0);

    // start_stop edge in the same cycle as a tick while running.
    press(1);
    press(0);
    ticks(41);
    settle();
    check("pre_coinc", 20'h00041, 1'b1, 1'b0);
    @(negedge clk) clk100 = 1'b1;
    @(negedge clk);
    @(negedge clk) begin clk100 = 1'b0; start_stop = 1'b1; end
    @(negedge clk) start_stop = 1'b0;
    settle();
    check("coinc", 20'h00042, 1'b0, 1'b0);
    ticks(5);
    settle();
    check("coinc_hold", 20'h00042, 1'b0, 1'b0);

    // clear and start_stop together from HOLD.
    press(1);
    press(0);
    ticks(307);
    press(0);
    check("hold_307", 20'h00307, 1'b0, 1'b0);
    @(negedge clk) begin clear = 1'b1; start_stop = 1'b1; end
    @(negedge clk) begin clear = 1'b0; start_stop = 1'b0; end
    settle();
    check("clr_ss", 20'h00000, 1'b0, 1'b0);
    ticks(3);
    settle();
    check("clr_ss_idle", 20'h00000, 1'b0, 1'b0);

    // Asynchronous reset mid-run.
    press(0);
    ticks(555);
    settle();
    check("pre_reset", 20'h00555, 1'b1, 1'b0);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #2 check("async_reset", 20'h00000, 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    ticks(5);
    settle();
    check("post_reset_idle", 20'h00000, 1'b0, 1'b0);
    press(0);
    ticks(3);
    settle();
    check("post_reset_run", 20'h00003, 1'b1, 1'b0);

    // Lap behaviour.
    press(1);
    press(0);
    ticks(200);
    settle();
    press(2);
`ifdef STOPWATCH_LAP_EN
    check("lap_capture", 20'h00200, 1'b1, 1'b1);
    ticks(100);
    settle();
    check("lap_frozen", 20'h00200, 1'b1, 1'b1);
    press(2);
    check("lap_release", 20'h00300, 1'b1, 1'b0);
`else
    check("lap_ignored", 20'h00200, 1'b1, 1'b0);
    ticks(100);
    settle();
    check("lap_tracks", 20'h00300, 1'b1, 1'b0);
    press(2);
    check("lap_ignored2", 20'h00300, 1'b1, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
